sram_rw_arbiter: RTL
====================

Name: sram_rw_arbiter

Overview:
- Shares one single-port SRAM macro (RW0-style: en/wmode/addr/wdata, read data valid one cycle after a read) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready read-response channel.
- Arbitration is round-robin. Read responses are steered back to the issuing port through a 2-entry response FIFO per port.
- Sits between two cache/tag-side clients and one `*_ext` array macro.

Parameters:
- ADDR_W, 12, macro address width (depth = 2^ADDR_W).
- DATA_W, 15, macro data width.
- RESP_DEPTH, 2, per-port response FIFO depth; fixed at 2, other values unsupported.

Ports:
- clock  in  1  single clock; also drives macro RW0_clk externally.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port request accepted this cycle when valid & ready.
- req_wmode  in  2  per-port write mode: 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-port write data.
- resp_valid  out  2  per-port read data valid.
- resp_ready  in  2  per-port response consume.
- resp_data  out  2*DATA_W  per-port read data.
- mem_addr  out  ADDR_W  to macro RW0_addr.
- mem_en  out  1  to macro RW0_en.
- mem_wmode  out  1  to macro RW0_wmode.
- mem_wdata  out  DATA_W  to macro RW0_wdata.
- mem_rdata  in  DATA_W  from macro RW0_rdata; valid the cycle after a read enable.

Behaviour:
- Reset values:
  - req_ready=0, resp_valid=0, resp_data=0.
  - mem_en=0; mem_addr/mem_wdata/mem_wmode=0.
  - last_grant=1, so port 0 wins the first contention.
- Credits:
  - cnt_i = FIFO occupancy_i + (read in flight to port i ? 1 : 0).
  - pop_i = resp_valid_i & resp_ready_i.
- Eligibility:
  - A write on port i is always eligible.
  - A read on port i is eligible iff cnt_i - pop_i < 2. The pop bypass makes req_ready combinationally depend on resp_ready.
- Arbitration (combinational, same cycle):
  - Among eligible valid ports, the port != last_grant wins. A single eligible port wins outright.
  - req_ready_i = 1 only for the winner, at most one bit per cycle.
  - last_grant updates only on an accept.
- Issue:
  - On accept, the same cycle: mem_en=1, mem_wmode/addr/wdata are taken from the winner.
  - No accept: mem_en=0, other mem outputs hold their last driven value.
- Read pipeline:
  - Registers rd_pend and rd_port are set on a read accept.
  - Cycle N accept → cycle N+1 mem_rdata valid → pushed into FIFO[rd_port] at the N+1 edge → resp_valid from N+2.
  - Minimum read latency is 2 cycles. Writes produce no response.
- Throughput:
  - Back-to-back reads from one port with resp_ready held 1 are sustained at 1/cycle.
  - Alternating ports are also 1/cycle.
- FIFO:
  - In order; simultaneous push and pop allowed.
  - Push into a full FIFO is impossible by credit rule; assert this in simulation.
  - resp_data is the head entry and is stable while resp_valid & !resp_ready.
- Read-after-write, same address, back-to-back accepts: the read returns the new data, since the macro is sequential.
- Reset mid-operation:
  - The in-flight read is dropped and FIFOs are emptied.
  - mem_en=0 immediately (asynchronous).
  - last_grant returns to 1.
- Parity: no ECC or parity; data is passed through unmodified.

Decomposition:
- Package sram_arb_pkg holds ADDR_W/DATA_W defaults, the NUM_PORTS=2 constant and the port-index type.
- Sub-module sram_resp_fifo: 2-entry, DATA_W wide, push/pop/full/empty/count, async reset. Instantiated twice.
- Arbiter, credit logic and read-tag registers live in the top.

Test Plan:
- Single read: after preload write port0 addr 0x005 data 0x1234, port0 reads 0x005 at cycle N → resp_valid[0] at N+2 with 0x1234; port1 silent.
- Contention: both ports valid every cycle for 6 cycles (port0 reads 0x010..; port1 writes 0x100..) → grants alternate 0,1,0,1,0,1 starting with port0 after reset.
- Backpressure: port1 issues 4 reads, resp_ready[1]=0 → exactly 2 accepted, then req_ready[1]=0. Raising resp_ready[1] → data returns in order, remaining reads accepted.
- Streaming: port0 issues reads of 0x000..0x00F with resp_ready[0]=1 → 16 accepts in 16 consecutive cycles; responses in order, first at +2.
- RAW: port0 writes 0x7FF=0x2AAA, then reads 0x7FF the next cycle → response 0x2AAA.
- Reset mid-flight: assert reset in the cycle after a read accept → no resp_valid afterwards, mem_en=0 during reset, first post-reset contention granted to port0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared constants and port-index type for the two-port SRAM arbiter
package sram_arb_pkg;
  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 15;
  localparam int NUM_PORTS = 2;
  localparam int RESP_DEPTH_FIXED = 2;
  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;
endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: 2-entry in-order read-response FIFO (push/pop/data_i in; data_o head, full_o, empty_o, count_o out)
module sram_resp_fifo #(
  parameter int DW = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [1:0]    count_o
);
  logic [DW-1:0] mem_q [2];
  logic          wr_q, rd_q;
  logic [1:0]    cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign count_o = cnt_q;
endmodule

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: round-robin sharing of one RW SRAM port between two valid/ready requesters (req_*/resp_* per port, mem_* to macro)
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int RESP_DEPTH = RESP_DEPTH_FIXED
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_PORTS-1:0]          req_valid_i,
  output logic [NUM_PORTS-1:0]          req_ready_o,
  input  logic [NUM_PORTS-1:0]          req_wmode_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_PORTS-1:0]          resp_valid_o,
  input  logic [NUM_PORTS-1:0]          resp_ready_i,
  output logic [NUM_PORTS*DATA_W-1:0]   resp_data_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_en_o,
  output logic                          mem_wmode_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i
);
  port_idx_t last_q, rd_port_q, win;
  logic rd_pend_q, wmode_q, acc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NUM_PORTS-1:0] pop, push, elig, empty, full;
  logic [1:0] occ [NUM_PORTS];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [1:0] cnt;
    assign pop[i]  = resp_valid_o[i] & resp_ready_i[i];
    assign push[i] = rd_pend_q & (rd_port_q == port_idx_t'(i));
    // the read in flight to this port is exactly the one pushed at the next edge
    assign cnt     = occ[i] + 2'(push[i]);
    // a pop this cycle frees a slot early so a stream can run at one read per cycle
    assign elig[i] = !reset_i & req_valid_i[i] &
                     (req_wmode_i[i] | (3'(cnt) < 3'(RESP_DEPTH) + 3'(pop[i])));
    assign resp_valid_o[i] = !empty[i];
    sram_resp_fifo #(.DW(DATA_W)) u_fifo (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (mem_rdata_i),
      .data_o  (resp_data_o[i*DATA_W +: DATA_W]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .count_o (occ[i])
    );
    a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i) push[i] |-> !full[i]);
  end
  assign acc         = |elig;
  assign win         = &elig ? ~last_q : port_idx_t'(elig[1]);
  assign req_ready_o = acc ? NUM_PORTS'(1) << win : '0;
  assign mem_en_o    = acc;
  assign mem_addr_o  = acc ? req_addr_i[win*ADDR_W +: ADDR_W] : addr_q;
  assign mem_wdata_o = acc ? req_wdata_i[win*DATA_W +: DATA_W] : wdata_q;
  assign mem_wmode_o = acc ? req_wmode_i[win] : wmode_q;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      last_q    <= port_idx_t'(1);
      rd_port_q <= '0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmode_q   <= 1'b0;
    end else begin
      rd_pend_q <= acc & !mem_wmode_o;
      if (acc) begin
        last_q    <= win;
        rd_port_q <= win;
      end
      addr_q  <= mem_addr_o;
      wdata_q <= mem_wdata_o;
      wmode_q <= mem_wmode_o;
    end
endmodule
